// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    localparam int unsigned SRAM_AW   = 18;
    localparam int unsigned SRAM_DW   = 16;
    localparam int unsigned RD_PHASES = 4;
    localparam int unsigned WR_PHASES = 2;

endpackage

// File: rtl/sram_controller_if.sv
// Cache-side request/response bus of the SRAM controller.
interface sram_controller_if;

    logic [31:0] address;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic [63:0] rdata;
    logic        ready;

    modport master (output address, wdata, wr_en, rd_en, input rdata, ready);
    modport slave  (input address, wdata, wr_en, rd_en, output rdata, ready);

endinterface

// File: rtl/sram_controller.sv
// Serves cache line fills (4 halfwords) and write-through words (2 halfwords)
// from a 16-bit asynchronous SRAM; completion is a one-cycle ready pulse.
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_BASE   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam logic [2:0] LAST_CYCLE = 3'(WAIT_CYCLES);
    localparam logic [1:0] RD_LAST    = 2'(RD_PHASES - 1);
    localparam logic [1:0] WR_LAST    = 2'(WR_PHASES - 1);

    state_e      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;

    logic [31:0] offset;
    logic        last_cycle;
    logic        dq_oe;
    logic [15:0] dq_out;

    assign offset     = bus.address - 32'(ADDR_BASE);
    assign last_cycle = (cnt_q == LAST_CYCLE);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.wr_en || bus.rd_en) begin
                    state_d = bus.wr_en ? WR : RD;
                    phase_d = '0;
                    cnt_d   = '0;
                    addr_d  = offset[18:2];
                    wdata_d = bus.wdata;
                end
            end
            RD: begin
                if (last_cycle) begin
                    // Data has had the full phase to settle; capture before the address moves.
                    rdata_d[{phase_q, 4'b0000} +: SRAM_DW] = SRAM_DQ;
                    cnt_d = '0;
                    if (phase_q == RD_LAST) state_d = DONE;
                    else                    phase_d = phase_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WR: begin
                if (last_cycle) begin
                    cnt_d = '0;
                    if (phase_q == WR_LAST) state_d = DONE;
                    else                    phase_d = phase_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // SRAM strobes depend on registers only; WE_N rises one cycle before the address moves.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_oe     = 1'b0;
        unique case (state_q)
            RD: begin
                SRAM_ADDR = {addr_q[16:1], phase_q};
                SRAM_OE_N = 1'b0;
            end
            WR: begin
                SRAM_ADDR = {addr_q, phase_q[0]};
                SRAM_WE_N = last_cycle;
                dq_oe     = 1'b1;
            end
            default: ;
        endcase
    end

    assign dq_out  = phase_q[0] ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    assign SRAM_CE_N = ~rst;
    assign SRAM_UB_N = ~rst;
    assign SRAM_LB_N = ~rst;

    assign bus.ready = (state_q == DONE);
    assign bus.rdata = rdata_q;

endmodule
